// File: rtl/ecc_secded_memory.sv
// ecc_secded_memory: SECDED-protected single-port word memory with saturating error counters; define ECC_SCRUB_EN to write corrected words back after a correctable read
module ecc_secded_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    localparam int R = DATA_W <= 4 ? 3 : DATA_W <= 11 ? 4 : DATA_W <= 26 ? 5 : DATA_W <= 57 ? 6 : 7,
    localparam int ECC_W = R + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [DATA_W+ECC_W-1:0] inj_flip,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ECC_W-1:0]        rsp_ecc,
    output logic                    err_corr,
    output logic                    err_uncorr,
    output logic [15:0]             corr_cnt,
    output logic [15:0]             uncorr_cnt
);
    localparam int N = DATA_W + R;
    localparam int CW = DATA_W + ECC_W;
`ifdef ECC_SCRUB_EN
    localparam bit SCRUB_EN = 1'b1;
`else
    localparam bit SCRUB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, SCRUB} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     mem [2**ADDR_W];
    logic [CW-1:0]     cw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [R-1:0]      syn;
    logic [DATA_W-1:0] fix_data;
    logic              par_err, corr, uncorr, wr_acc, rd_acc;

    // Check bits for a data word: Hamming bits at power-of-two positions plus overall parity on top
    function automatic logic [ECC_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [ECC_W-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < R; i++)
                    if (p[i]) c[i] = c[i] ^ d[k];
                k++;
            end
        end
        c[R] = ^{c[R-1:0], d};
        return c;
    endfunction

    assign req_ready = (state == IDLE);
    assign wr_acc = rst && req_ready && req_valid && req_we;
    assign rd_acc = rst && req_ready && req_valid && !req_we;

    // Syndrome, overall parity and single-bit repair of the latched codeword
    always_comb begin
        int k, j;
        syn = '0;
        fix_data = cw_q[DATA_W-1:0];
        k = 0;
        j = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) == 0) begin
                if (cw_q[DATA_W+j]) syn = syn ^ p[R-1:0];
                j++;
            end else begin
                if (cw_q[k]) syn = syn ^ p[R-1:0];
                k++;
            end
        end
        par_err = ^cw_q;
        corr = par_err && int'(syn) <= N;
        uncorr = (par_err || syn != '0) && !corr;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (corr && p == int'(syn)) fix_data[k] = ~fix_data[k];
                k++;
            end
        end
    end

    // Next state: reads take one decode cycle, optionally followed by a write-back cycle
    always_comb begin
        state_nx = state;
        if (rd_acc) state_nx = RD;
        else if (state == RD) state_nx = (SCRUB_EN && corr) ? SCRUB : IDLE;
        else if (state == SCRUB) state_nx = IDLE;
    end

    // Storage and read latch, not reset; scrub rewrites the corrected word with fresh check bits
    always_ff @(posedge clk) begin
        if (wr_acc) mem[req_addr] <= {encode(req_wdata), req_wdata} ^ inj_flip;
        else if (state == SCRUB) mem[addr_q] <= {encode(rsp_data), rsp_data};
        if (rd_acc) begin
            cw_q <= mem[req_addr];
            addr_q <= req_addr;
        end
    end

    // State, response registers and saturating error counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_ecc <= '0;
            err_corr <= 1'b0;
            err_uncorr <= 1'b0;
            corr_cnt <= '0;
            uncorr_cnt <= '0;
        end else begin
            state <= state_nx;
            rsp_valid <= (state == RD);
            if (state == RD) begin
                rsp_data <= fix_data;
                rsp_ecc <= cw_q[CW-1:DATA_W];
                err_corr <= corr;
                err_uncorr <= uncorr;
                corr_cnt <= corr_cnt + 16'(corr && corr_cnt != 16'hFFFF);
                uncorr_cnt <= uncorr_cnt + 16'(uncorr && uncorr_cnt != 16'hFFFF);
            end
        end
    end
endmodule

// File: doc/ecc_secded_memory.md
ECC_SECDED_MEMORY -- requirements
Module: ecc_secded_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (legal 4..64).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth 2**ADDR_W words.
REQ-003 SHALL have localparam ECC_W = R+1, where R is the smallest value with 2**R >= DATA_W+R+1; for DATA_W=8, ECC_W=5.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted when high with req_valid.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W: word address.
REQ-010 SHALL have port req_wdata, input, DATA_W: write data.
REQ-011 SHALL have port inj_flip, input, DATA_W+ECC_W: bits XORed into the codeword stored on a write (error injection).
REQ-012 SHALL have port rsp_valid, output, 1: one-cycle read-response strobe, no backpressure.
REQ-013 SHALL have port rsp_data, output, DATA_W: corrected read data.
REQ-014 SHALL have port rsp_ecc, output, ECC_W: stored check bits of the read word.
REQ-015 SHALL have ports err_corr and err_uncorr, outputs, 1 each: error flags qualified by rsp_valid.
REQ-016 SHALL have ports corr_cnt and uncorr_cnt, outputs, 16 each: saturating event counters.

Function
REQ-017 SHALL encode as Hamming SECDED: positions 1..DATA_W+R, check bit i at position 2**i, data bits filling the remaining positions in ascending order, and an overall even-parity bit over all positions as ECC bit R.
REQ-018 SHALL store the codeword {check, data} XOR inj_flip on an accepted write, completing at the acceptance edge with no response.
REQ-019 SHALL use states IDLE, RD and SCRUB; req_ready = 1 only in IDLE.
REQ-020 SHALL, on a read accepted at edge E0, latch the stored codeword and enter RD; at E1 register the decode results, drive rsp_valid high for the cycle after E1, and leave RD.
REQ-021 SHALL report syndrome 0 with overall parity OK as clean: err_corr=0, err_uncorr=0.
REQ-022 SHALL treat an overall-parity mismatch as correctable: flip the addressed bit (none if syndrome 0), set err_corr=1, and increment corr_cnt.
REQ-023 SHALL treat a nonzero syndrome with overall parity OK as uncorrectable: return the raw data bits, set err_uncorr=1, and increment uncorr_cnt.
REQ-024 SHALL treat a syndrome pointing beyond the codeword as uncorrectable.
REQ-025 SHALL saturate both counters at 16'hFFFF with no wrap.
REQ-026 SHALL hold rsp_data, rsp_ecc, err_corr and err_uncorr until the next response.
REQ-027 SHALL leave reads of never-written addresses undefined; the bench writes first.

Reset
REQ-028 SHALL, on rst low, immediately set state IDLE and set rsp_valid, rsp_data, rsp_ecc, error flags and counters to 0; the memory array is not reset.
REQ-029 SHALL drop any read or scrub in flight when rst is asserted, with no rsp_valid afterwards.

Configuration
REQ-030 SHALL, with ECC_SCRUB_EN defined, go RD->SCRUB after a correctable error and, in SCRUB, rewrite the corrected codeword (recomputed check bits, no injection) to the read address, holding req_ready low for that cycle, then return to IDLE.
REQ-031 SHALL, without ECC_SCRUB_EN, go RD->IDLE always and never modify stored data on a read.

Verification (DATA_W=8, ADDR_W=8)
REQ-032 SHALL cover: write 0xA5 @0x10, inj_flip=0; read 0x10 -> rsp_valid 2 cycles after acceptance, rsp_data=0xA5, flags 0, counters 0.
REQ-033 SHALL cover: write 0x3C @0x20 with inj_flip=13'h0004; read -> rsp_data=0x3C, err_corr=1, corr_cnt=1; with ECC_SCRUB_EN a second read gives err_corr=0, without it err_corr=1 and corr_cnt=2.
REQ-034 SHALL cover: write 0xFF @0x30 with inj_flip=13'h0003; read -> err_uncorr=1, uncorr_cnt=1, err_corr=0.
REQ-035 SHALL cover: write @0x40 with inj_flip=13'h1000 (overall parity bit); read -> data exact, err_corr=1.
REQ-036 SHALL cover: assert rst during RD -> no rsp_valid, outputs 0, req_ready=1 after release; data at 0x10 is still 0xA5.
REQ-037 SHALL cover: force corr_cnt to 16'hFFFE, then two correctable reads -> corr_cnt holds 16'hFFFF.
